// File: rtl/adc_trigger_capture.sv
// Circular-buffer ADC capture with pre/post-trigger windows and level/slope/forced triggering.
// Write port is registered one cycle behind s_valid; no backpressure, every active s_valid sample is stored.
module adc_trigger_capture #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_otr,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    input  logic              trig_slope,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W-1:0] pre_samples,
    input  logic [ADDR_W-1:0] post_samples,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);

    localparam int PAD_W = 31 - DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_pre;
    logic [ADDR_W-1:0]   r_post;
    logic [DATA_W-1:0]   r_level;
    logic                r_slope;
    logic [DATA_W-1:0]   r_prev;
    logic                r_prev_vld;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_busy;
    logic                r_triggered;
    logic                r_done;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic [ADDR_W-1:0]   r_start_addr;

    logic                w_active;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_post_eff;
    logic [ADDR_W-1:0]   w_cnt_inc;
    logic                w_rise;
    logic                w_fall;
    logic                w_hit;
    logic [31:0]         w_wdata;

    assign w_active   = (r_state == ST_PREFILL) || (r_state == ST_WAIT_TRIG) || (r_state == ST_POST);
    // arm/abort own the cycle they arrive in: the sample presented alongside them is not stored
    assign w_wr       = s_valid && w_active && !arm && !abort;
    assign w_post_eff = (r_post == '0) ? ADDR_W'(1) : r_post;
    assign w_cnt_inc  = r_cnt + ADDR_W'(1);
    assign w_rise     = (r_prev < r_level) && (s_data >= r_level);
    assign w_fall     = (r_prev > r_level) && (s_data <= r_level);
    assign w_hit      = force_trig || (r_prev_vld && (r_slope ? w_fall : w_rise));
    assign w_wdata    = {{PAD_W{1'b0}}, s_otr, s_data};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_pre        <= '0;
            r_post       <= '0;
            r_level      <= '0;
            r_slope      <= 1'b0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
        end else begin
            r_mem_we <= w_wr;
            // done trails entry into DONE by one cycle so it never overlaps the final write strobe
            r_done   <= (r_state == ST_DONE) && !arm && !abort;

            if (w_wr) begin
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= w_wdata;
                r_ptr       <= r_ptr + ADDR_W'(1);
                r_prev      <= s_data;
                r_prev_vld  <= 1'b1;
            end

            if (abort) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_triggered <= 1'b0;
            end else if (arm) begin
                r_pre       <= pre_samples;
                r_post      <= post_samples;
                r_level     <= trig_level;
                r_slope     <= trig_slope;
                r_triggered <= 1'b0;
                r_prev_vld  <= 1'b0;
                r_cnt       <= '0;
                r_busy      <= 1'b1;
                r_state     <= (pre_samples == '0) ? ST_WAIT_TRIG : ST_PREFILL;
            end else if (w_wr) begin
                case (r_state)
                    ST_PREFILL: begin
                        if (w_cnt_inc == r_pre) begin
                            r_state <= ST_WAIT_TRIG;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (w_hit) begin
                            r_trig_addr  <= r_ptr;
                            r_start_addr <= r_ptr - r_pre;
                            r_triggered  <= 1'b1;
                            r_cnt        <= ADDR_W'(1);
                            if (w_post_eff == ADDR_W'(1)) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (w_cnt_inc == w_post_eff) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign triggered  = r_triggered;
    assign done       = r_done;
    assign trig_addr  = r_trig_addr;
    assign start_addr = r_start_addr;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Scoreboard bench for adc_trigger_capture: stimulus pushes expected BRAM writes, a monitor pops them.
// Status outputs are compared every cycle against a sample-counting reference model.
module tb_adc_trigger_capture;

    localparam int AW    = 4;
    localparam int DW    = 12;
    localparam int DEPTH = 16;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_otr = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          force_trig = 1'b0;
    logic          trig_slope = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic [AW-1:0] pre_samples = '0;
    logic [AW-1:0] post_samples = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;

    always #5 clk_i = ~clk_i;

    adc_trigger_capture #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_otr(s_otr),
        .arm(arm), .abort(abort), .force_trig(force_trig), .trig_slope(trig_slope),
        .trig_level(trig_level), .pre_samples(pre_samples), .post_samples(post_samples),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .triggered(triggered), .done(done), .trig_addr(trig_addr), .start_addr(start_addr)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    // Reference model: counts of samples kept before and after the trigger
    int m_ptr, m_nwr, m_npost, m_pre, m_post, m_lvl, m_prev;
    bit m_active, m_trig, m_prev_vld, m_slope, m_done_flag;
    bit e_busy, e_done, e_trig;
    int e_taddr, e_saddr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_nwr = 0; m_npost = 0; m_pre = 0; m_post = 0; m_lvl = 0; m_prev = 0;
        m_active = 0; m_trig = 0; m_prev_vld = 0; m_slope = 0; m_done_flag = 0;
        e_busy = 0; e_done = 0; e_trig = 0; e_taddr = 0; e_saddr = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit done_vis;
        int post_eff;
        int cur;
        bit hit;
        done_vis = m_done_flag && !arm && !abort;
        if (abort) begin
            m_active = 0; m_done_flag = 0; e_trig = 0;
        end else if (arm) begin
            m_pre = pre_samples; m_post = post_samples; m_lvl = trig_level; m_slope = trig_slope;
            m_active = 1; m_nwr = 0; m_trig = 0; m_npost = 0; m_prev_vld = 0;
            m_done_flag = 0; e_trig = 0;
        end else if (m_active && s_valid) begin
            cur = s_data;
            post_eff = (m_post == 0) ? 1 : m_post;
            exp_q.push_back({AW'(m_ptr), {19'b0, s_otr, s_data}});
            if (!m_trig && m_nwr < m_pre) begin
                m_nwr++;
            end else if (!m_trig) begin
                if (m_slope) hit = (m_prev > m_lvl) && (cur <= m_lvl);
                else         hit = (m_prev < m_lvl) && (cur >= m_lvl);
                if (force_trig || (m_prev_vld && hit)) begin
                    m_trig = 1; e_trig = 1; m_npost = 1;
                    e_taddr = m_ptr;
                    e_saddr = ((m_ptr - m_pre) % DEPTH + DEPTH) % DEPTH;
                end
            end else begin
                m_npost++;
            end
            if (m_trig && m_npost >= post_eff) begin
                m_active = 0; m_done_flag = 1;
            end
            m_prev = cur; m_prev_vld = 1;
            m_ptr = (m_ptr + 1) % DEPTH;
        end
        e_busy = m_active;
        e_done = done_vis;
    endtask

    // Inputs change only just after the falling edge; the monitor samples 2 time units after the rising edge
    task automatic step(input bit v, input int d, input bit o);
        s_valid = v; s_data = d[DW-1:0]; s_otr = o;
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        arm = 0; abort = 0;
    endtask

    task automatic do_arm(input int pre, input int post, input int lvl, input bit slope);
        pre_samples = AW'(pre); post_samples = AW'(post);
        trig_level = DW'(lvl); trig_slope = slope;
        arm = 1;
        step(0, 0, 0);
    endtask

    task automatic do_abort();
        abort = 1;
        step(0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_triggered"}, 32'(triggered), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_trig_addr"}, 32'(trig_addr), 0);
        chk({tag, "_start_addr"}, 32'(start_addr), 0);
    endtask

    initial begin
        wr_t e;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_n) begin
                if (mem_we) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e.a));
                        chk("wr_data", mem_wdata, e.d);
                    end
                end
                chk("busy", 32'(busy), 32'(e_busy));
                chk("done", 32'(done), 32'(e_done));
                chk("triggered", 32'(triggered), 32'(e_trig));
                chk("trig_addr", 32'(trig_addr), 32'(e_taddr));
                chk("start_addr", 32'(start_addr), 32'(e_saddr));
            end
        end
    end

    initial begin
        int base;
        int k;
        model_reset();
        #13;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_n = 1;
        step(0, 0, 0);

        // Rising ramp, pre=4 post=4
        base = m_ptr;
        do_arm(4, 4, 'h800, 0);
        for (int i = 0; i < 12; i++) step(1, 'h7F0 + 4 * i, i[0]);
        step(0, 0, 0);
        chk("t1_trig_addr", 32'(trig_addr), 32'((base + 4) % DEPTH));
        chk("t1_start_addr", 32'(start_addr), 32'(base % DEPTH));
        chk("t1_done", 32'(done), 1);

        // Falling edge: triggers on 0x400 after 0x401
        base = m_ptr;
        do_arm(0, 2, 'h400, 1);
        step(1, 'h500, 0); step(1, 'h401, 0); step(1, 'h400, 1); step(1, 'h3F0, 0);
        step(0, 0, 0);
        chk("t2_trig_addr", 32'(trig_addr), 32'((base + 2) % DEPTH));
        // Equal-to-level runs never trigger
        do_arm(0, 1, 'h400, 1);
        step(1, 'h400, 0); step(1, 'h400, 0); step(1, 'h400, 0); step(1, 'h3FF, 0); step(1, 'h500, 0);
        chk("t2_no_trig", 32'(triggered), 0);
        do_abort();

        // Move pointer to 14, then forced capture wraps 14,15,0,1,2
        k = ((13 - m_ptr) % DEPTH + DEPTH) % DEPTH;
        force_trig = 1;
        do_arm(k, 1, 0, 0);
        for (int i = 0; i <= k; i++) step(1, 'h100 + i, 0);
        step(0, 0, 0);
        do_arm(0, 5, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 'hA00 + i, i[0]);
        force_trig = 0;
        chk("t3_trig_addr", 32'(trig_addr), 14);
        chk("t3_start_addr", 32'(start_addr), 14);

        // s_valid toggling in POST, post=3
        do_arm(2, 3, 'h800, 0);
        step(1, 'h100, 0); step(1, 'h200, 0); step(1, 'h900, 0);
        for (int i = 0; i < 8; i++) step(i[0], 'h900 + 16 * i, 0);

        // Abort in WAIT_TRIG, then arm+abort together, then arm alone
        do_arm(1, 2, 'hFFF, 0);
        step(1, 'h10, 0); step(1, 'h20, 0); step(1, 'h30, 0);
        abort = 1; step(1, 'h40, 0);
        step(1, 'h50, 0); step(1, 'h60, 0);
        arm = 1; abort = 1; step(1, 'h70, 0);
        step(1, 'h80, 0); step(1, 'h90, 0);
        chk("t5_busy_idle", 32'(busy), 0);
        do_arm(1, 2, 'hFFF, 0);
        chk("t5_rearm_trig", 32'(triggered), 0);
        chk("t5_rearm_busy", 32'(busy), 1);
        do_abort();

        // Randomised captures, including pre+post > DEPTH
        for (int r = 0; r < 20; r++) begin
            do_arm($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 50; c++) begin
                force_trig = ($urandom_range(0, 19) == 0);
                step($urandom_range(0, 9) < 7, $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
            end
            force_trig = 0;
            do_abort();
        end

        // Asynchronous reset in the middle of POST
        do_arm(2, 10, 'h800, 0);
        force_trig = 1;
        for (int i = 0; i < 5; i++) step(1, 'h300 + i, 0);
        force_trig = 0;
        chk("t6_in_post", 32'(busy), 1);
        #2 rst_n = 0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(negedge clk_i);
        rst_n = 1;
        force_trig = 1;
        do_arm(0, 1, 0, 0);
        step(1, 'h123, 1);
        force_trig = 0;
        step(0, 0, 0);
        chk("t6_ptr_zero", 32'(trig_addr), 0);

        step(0, 0, 0); step(0, 0, 0);
        chk("pending_writes", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_trigger_capture.md
Name: adc_trigger_capture

Overview:
Sits directly downstream of the ADC acquisition stage and consumes its 12-bit sample stream and out-of-range flag. It runs a circular-buffer capture into a dual-port BRAM, with a programmable pre-trigger count, a programmable post-trigger count, and level/slope or forced triggering. It reports trigger and start addresses so the host readout can unroll the buffer.

Parameters:
ADDR_W, 12, BRAM address width; buffer depth DEPTH = 2^ADDR_W samples
DATA_W, 12, ADC sample width

Ports:
clk_i  in  1  sample clock; same clock as the acquisition stage
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  sample strobe (the upstream write-enable)
s_data  in  DATA_W  ADC sample, unsigned offset-binary
s_otr  in  1  ADC out-of-range flag for s_data
arm  in  1  single-cycle pulse; starts a new capture
abort  in  1  single-cycle pulse; returns to IDLE
force_trig  in  1  level-sensitive; triggers unconditionally once armed and pre-fill is complete
trig_slope  in  1  0 = rising edge, 1 = falling edge
trig_level  in  DATA_W  trigger threshold
pre_samples  in  ADDR_W  samples kept before the trigger
post_samples  in  ADDR_W  samples kept from the trigger onward; 0 is treated as 1
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM write address
mem_wdata  out  32  {19'b0, otr, data}
busy  out  1  high in PREFILL, WAIT_TRIG, POST
triggered  out  1  set at the trigger; cleared on arm, abort or reset
done  out  1  high in DONE
trig_addr  out  ADDR_W  BRAM address of the trigger sample
start_addr  out  ADDR_W  address of the oldest kept sample: (trig_addr - pre_samples) mod DEPTH

Behaviour:
- Reset: state IDLE. All outputs are 0, including mem_we, mem_addr, mem_wdata, trig_addr and start_addr. Write pointer = 0. Previous-sample-valid flag = 0.
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
- arm, from any state: latch pre_samples, post_samples, trig_level and trig_slope into shadow registers. Clear triggered, clear the prev-valid flag, zero the fill counter. Write pointer is kept (continues circularly). Next state: PREFILL, or WAIT_TRIG if the latched pre = 0.
- abort: next state IDLE, flags cleared. If arm and abort are asserted in the same cycle, abort wins.
- Writes: every s_valid cycle in PREFILL, WAIT_TRIG or POST writes the sample.
  - mem_we, mem_addr and mem_wdata are registered, with 1-cycle latency from s_valid.
  - The pointer increments after each write and wraps DEPTH-1 -> 0.
  - No writes occur in IDLE or DONE.
- PREFILL: count written samples. After the pre-th write, go to WAIT_TRIG. Trigger conditions are ignored in PREFILL.
- Trigger condition, evaluated only on an s_valid cycle with prev-valid = 1:
  - Rising: prev < level and cur >= level.
  - Falling: prev > level and cur <= level.
  - force_trig = 1 with s_valid triggers regardless.
  - prev is updated on every s_valid cycle in the active states. prev-valid is set after the first valid sample following arm.
- Trigger sample: written normally. trig_addr = its write address, start_addr computed, triggered = 1, and it counts as post sample #1. Next state: POST, or DONE if post = 1.
- POST: after the post-th sample (counting the trigger sample) is written, go to DONE.
  - done rises in the cycle after the final mem_we, so mem_we and done never assert together.
- DONE holds until arm, abort or reset.
- If pre + post > DEPTH, older pre-trigger samples are overwritten. start_addr is still computed modulo DEPTH, and no error is flagged.
- s_otr is stored with each sample only; it does not affect triggering.
- s_valid low: no write and no counter change, in any state.

Test Plan:
1. ADDR_W=4, pre=4, post=4, level=0x800, rising; ramp 0x7F0 +4/sample from arm -> 4 prefill writes, trigger on first sample >= 0x800 at addr A; trig_addr=A, start_addr=A-4 mod 16, exactly 8 total writes after the trigger's prefill, done 1 cycle after last mem_we.
2. Falling slope, level=0x400; data 0x500,0x401,0x400 -> trigger on 0x400, not 0x401; a sample equal to level with prev equal to level never triggers.
3. Pointer at 14, pre=0, post=5, force_trig held -> writes to addresses 14,15,0,1,2; trig_addr=14, start_addr=14.
4. s_valid toggling 1/0 during POST with post=3 -> exactly 3 writes; done timing tracks the third write, and no writes occur while s_valid=0.
5. Abort in WAIT_TRIG, then arm and abort in the same cycle -> IDLE, busy=0, no further writes; then arm alone restarts with triggered=0.
6. rst_n asserted low mid-POST, asynchronously between clock edges -> all outputs 0 immediately, state IDLE, pointer 0.
